// File: rtl/hdmi_i2c_config_sequencer_pkg.sv
// Shared definitions for the HDMI transmitter I2C configuration sequencer:
// sequencer state encoding, field positions inside a 24-bit table word and
// the transmitter's 8-bit I2C slave address.
package hdmi_i2c_config_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POWERUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_ERROR
    } seq_state_e;

    localparam int SLAVE_MSB = 23;
    localparam int REG_MSB   = 15;
    localparam int DATA_MSB  = 7;

    localparam logic [7:0] HDMI_TX_ADDR = 8'h72;

endpackage

// File: rtl/hdmi_i2c_config_sequencer_rom.sv
// hdmi_config_rom: constant transmitter power-up register list.
// Ports:
//   index_i  entry index
//   word_o   {slave[23:16], register[15:8], data[7:0]}; zero for any index
//            at or beyond NUM_ENTRIES
module hdmi_config_rom
    import hdmi_i2c_config_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int INDEX_WIDTH = 8
) (
    input  logic [INDEX_WIDTH-1:0] index_i,
    output logic [23:0]            word_o
);

    logic [31:0] idx32;

    always_comb begin
        idx32  = 32'(index_i);
        word_o = '0;
        if (idx32 < 32'(NUM_ENTRIES)) begin
            case (idx32)
                32'd0:   word_o = {HDMI_TX_ADDR, 8'h41, 8'h10}; // power up
                32'd1:   word_o = {HDMI_TX_ADDR, 8'h98, 8'h03};
                32'd2:   word_o = {HDMI_TX_ADDR, 8'h9A, 8'hE0};
                32'd3:   word_o = {HDMI_TX_ADDR, 8'h9C, 8'h30};
                32'd4:   word_o = {HDMI_TX_ADDR, 8'h9D, 8'h61};
                32'd5:   word_o = {HDMI_TX_ADDR, 8'hA2, 8'hA4};
                32'd6:   word_o = {HDMI_TX_ADDR, 8'hA3, 8'hA4};
                32'd7:   word_o = {HDMI_TX_ADDR, 8'hE0, 8'hD0};
                32'd8:   word_o = {HDMI_TX_ADDR, 8'hF9, 8'h00};
                32'd9:   word_o = {HDMI_TX_ADDR, 8'h15, 8'h00}; // input format
                32'd10:  word_o = {HDMI_TX_ADDR, 8'h16, 8'h30};
                32'd11:  word_o = {HDMI_TX_ADDR, 8'h17, 8'h02};
                32'd12:  word_o = {HDMI_TX_ADDR, 8'h18, 8'h46};
                32'd13:  word_o = {HDMI_TX_ADDR, 8'hAF, 8'h06}; // HDMI mode
                32'd14:  word_o = {HDMI_TX_ADDR, 8'hBA, 8'h60};
                32'd15:  word_o = {HDMI_TX_ADDR, 8'hD6, 8'hC0};
                default: word_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_i2c_config_sequencer.sv
// HDMI transmitter configuration sequencer. Walks the configuration ROM and
// hands one {slave, register, data} word at a time to the single-write I2C
// engine, retrying NACKed or timed-out writes up to MAX_RETRIES times.
// Ports:
//   refClock, reset_n    clock, synchronous active-low reset
//   start                begin a configuration pass (IDLE/DONE/ERROR only)
//   hpd                  hot-plug level, used only with HPD_RECONFIG_EN
//   cmdData, cmdGo       word and one-cycle request to the engine
//   cmdDone, cmdAckOk    engine completion pulse and ACK status
//   busy, done, error    pass status levels
//   failIndex            entry that aborted the pass, else 0
// Optional feature macro: HPD_RECONFIG_EN (hpd rising edge restarts a pass).
module hdmi_i2c_config_sequencer
    import hdmi_i2c_config_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES    = 16,
    parameter int INDEX_WIDTH    = 8,
    parameter int POWERUP_CYCLES = 1000,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   refClock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   hpd,
    output logic [23:0]            cmdData,
    output logic                   cmdGo,
    input  logic                   cmdDone,
    input  logic                   cmdAckOk,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [INDEX_WIDTH-1:0] failIndex
);

    seq_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] fail_q, fail_d;
    logic [7:0]             retries_q, retries_d;
    logic                   retry_q, retry_d;
    logic [23:0]            data_q, data_d;
    logic                   go_q, go_d;
    logic                   busy_q, done_q, error_q;
    logic [23:0]            rom_word;
    logic                   start_ev;

    hdmi_config_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rom (
        .index_i (idx_q),
        .word_o  (rom_word)
    );

`ifdef HPD_RECONFIG_EN
    logic hpd_q, pend_q, pend_d, hpd_rise;

    assign hpd_rise = hpd & ~hpd_q;
    // A pending request is only consumed in IDLE/DONE/ERROR, where it acts as start.
    assign start_ev = start | hpd_rise | pend_q;

    always_comb begin
        pend_d = pend_q;
        if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR) begin
            pend_d = 1'b0;
        end else if (hpd_rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            hpd_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            hpd_q  <= hpd;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_hpd;
    assign unused_hpd = hpd;
    assign start_ev   = start;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        fail_d    = fail_q;
        retries_d = retries_q;
        retry_d   = retry_q;
        data_d    = data_q;
        go_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ev) begin
                    state_d = S_POWERUP;
                    // One extra count so the first request trails start by
                    // POWERUP_CYCLES+2, matching the GAP->NEXT->ISSUE spacing.
                    cnt_d   = CNT_WIDTH'(POWERUP_CYCLES);
                end
            end
            S_POWERUP: begin
                if (cnt_q == '0) begin
                    idx_d     = '0;
                    retries_d = '0;
                    retry_d   = 1'b0;
                    state_d   = S_ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_ISSUE: begin
                data_d  = rom_word;
                go_d    = 1'b1;
                cnt_d   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cmdDone takes priority over a simultaneous timeout.
                if (cmdDone && cmdAckOk) begin
                    retry_d = 1'b0;
                    cnt_d   = CNT_WIDTH'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else if (cmdDone || cnt_q == '0) begin
                    if (retries_q < 8'(MAX_RETRIES)) begin
                        retries_d = retries_q + 8'd1;
                        retry_d   = 1'b1;
                        cnt_d     = CNT_WIDTH'(GAP_CYCLES - 1);
                        state_d   = S_GAP;
                    end else begin
                        fail_d  = idx_q;
                        state_d = S_ERROR;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_NEXT: begin
                // Retries also pass through NEXT so every reissue keeps the
                // same GAP_CYCLES+2 spacing; they do not advance the index.
                if (retry_q) begin
                    state_d = S_ISSUE;
                end else if (idx_q == INDEX_WIDTH'(NUM_ENTRIES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + INDEX_WIDTH'(1);
                    retries_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_DONE, S_ERROR: begin
                if (start_ev) begin
                    fail_d  = '0;
                    cnt_d   = CNT_WIDTH'(POWERUP_CYCLES);
                    state_d = S_POWERUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            fail_q    <= '0;
            retries_q <= '0;
            retry_q   <= 1'b0;
            data_q    <= '0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            fail_q    <= fail_d;
            retries_q <= retries_d;
            retry_q   <= retry_d;
            data_q    <= data_d;
            go_q      <= go_d;
            busy_q    <= !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERROR);
        end
    end

    assign cmdData   = data_q;
    assign cmdGo     = go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign failIndex = fail_q;

endmodule

// File: tb/tb_hdmi_i2c_config_sequencer.sv
// Self-checking bench for hdmi_i2c_config_sequencer with a small table and
// short delays. A timing model predicts every output each cycle from the
// start/engine events; directed tests add literal expectations.
module tb_hdmi_i2c_config_sequencer;

    localparam int N  = 4;
    localparam int P  = 10;
    localparam int G  = 8;
    localparam int T  = 64;
    localparam int MR = 2;
    localparam int IW = 8;
    localparam logic [23:0] TBL [4] = '{24'h724110, 24'h729803, 24'h729AE0, 24'h729C30};

    logic refClock = 1'b0;
    logic reset_n = 1'b0, start = 1'b0, hpd = 1'b0, cmdDone = 1'b0, cmdAckOk = 1'b0;
    logic [23:0] cmdData;
    logic cmdGo, busy, done, error;
    logic [IW-1:0] failIndex;

    always #5 refClock = ~refClock;

    hdmi_i2c_config_sequencer #(
        .NUM_ENTRIES    (N),
        .INDEX_WIDTH    (IW),
        .POWERUP_CYCLES (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T),
        .MAX_RETRIES    (MR),
        .CNT_WIDTH      (16)
    ) dut (
        .refClock (refClock), .reset_n (reset_n), .start (start), .hpd (hpd),
        .cmdData (cmdData), .cmdGo (cmdGo), .cmdDone (cmdDone), .cmdAckOk (cmdAckOk),
        .busy (busy), .done (done), .error (error), .failIndex (failIndex)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- timing model ----------------
    int cyc = 0;
    bit m_busy, m_done, m_err, m_go, m_wait, m_pend;
    int m_fail, m_idx, m_retries, m_go_edge;
    int m_go_at = -1, m_end_at = -1, m_restart_at = -1;
    logic [23:0] m_data = '0;
    logic hpd_prev = 1'b0;

    always @(posedge refClock) begin
        bit st, was_busy;
        cyc++;
        m_go = 0;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wait = 0; m_pend = 0;
            m_fail = 0; m_idx = 0; m_retries = 0;
            m_go_at = -1; m_end_at = -1; m_restart_at = -1;
            m_data = '0; hpd_prev = 1'b0;
        end else begin
            st = start;
`ifdef HPD_RECONFIG_EN
            if (hpd && !hpd_prev) begin
                if (m_busy) m_pend = 1; else st = 1;
            end
            if (m_restart_at == cyc) st = 1;
`endif
            hpd_prev = hpd;
            was_busy = m_busy;
            if (!m_busy) begin
                if (st) begin
                    m_busy = 1; m_done = 0; m_err = 0; m_fail = 0;
                    m_idx = 0; m_retries = 0; m_go_at = cyc + P + 2;
                end
            end else begin
                if (m_wait && (cmdDone || cyc == m_go_edge + T)) begin
                    m_wait = 0;
                    if (cmdDone && cmdAckOk) begin
                        if (m_idx == N - 1) m_end_at = cyc + G + 1;
                        else begin m_idx++; m_retries = 0; m_go_at = cyc + G + 2; end
                    end else if (m_retries < MR) begin
                        m_retries++; m_go_at = cyc + G + 2;
                    end else begin
                        m_busy = 0; m_err = 1; m_fail = m_idx;
                    end
                end
                if (m_go_at == cyc) begin
                    m_go = 1; m_wait = 1; m_go_edge = cyc; m_data = TBL[m_idx]; m_go_at = -1;
                end
                if (m_end_at == cyc) begin
                    m_busy = 0; m_done = 1; m_end_at = -1;
                end
            end
            if (was_busy && !m_busy && m_pend) begin
                m_pend = 0; m_restart_at = cyc + 1;
            end
        end
    end

    // ---------------- compare + measurement ----------------
    int go_cnt [4];
    int go_other = 0;
    int go_total = 0;
    int first_go_cyc = -1;
    logic [23:0] first_go_data = '0;
    int go_edges [$];

    always @(negedge refClock) begin
        if (cyc > 0) begin
            chk("cmdGo", 32'(cmdGo), 32'(m_go));
            chk("cmdData", 32'(cmdData), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("failIndex", 32'(failIndex), 32'(m_fail));
            if (cmdGo === 1'b1) begin
                bit hit = 0;
                for (int i = 0; i < 4; i++)
                    if (cmdData == TBL[i]) begin go_cnt[i]++; hit = 1; end
                if (!hit) go_other++;
                go_total++;
                go_edges.push_back(cyc);
                if (first_go_cyc < 0) begin first_go_cyc = cyc; first_go_data = cmdData; end
            end
        end
    end

    // ---------------- engine model ----------------
    int mode = 0;       // 0 ack all, 1 nack entry 2 once, 2 nack entry 1 always, 3 silent
    int nack2_left = 0;

    initial begin
        logic [23:0] w;
        bit ack;
        forever begin
            @(negedge refClock);
            if (cmdGo === 1'b1 && mode != 3) begin
                w = cmdData;
                repeat (4) @(negedge refClock);
                ack = 1;
                if (mode == 1 && w == TBL[2] && nack2_left > 0) begin ack = 0; nack2_left--; end
                if (mode == 2 && w == TBL[1]) ack = 0;
                cmdDone = 1'b1; cmdAckOk = ack;
                @(negedge refClock);
                cmdDone = 1'b0; cmdAckOk = 1'b0;
            end
        end
    end

    // ---------------- directed tests ----------------
    int start_cyc;

    task automatic clear_meas();
        for (int i = 0; i < 4; i++) go_cnt[i] = 0;
        go_other = 0; go_total = 0; first_go_cyc = -1;
        go_edges.delete();
    endtask

    task automatic pulse_start();
        @(negedge refClock);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge refClock);
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int lim);
        int k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < lim) begin
            @(negedge refClock);
            k++;
        end
        if (k >= lim) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no done/error within %0d cycles", nm, lim);
        end
    endtask

    task automatic chk_counts(input string nm, input int c0, input int c1, input int c2, input int c3);
        chk({nm, "_e0"}, 32'(go_cnt[0]), 32'(c0));
        chk({nm, "_e1"}, 32'(go_cnt[1]), 32'(c1));
        chk({nm, "_e2"}, 32'(go_cnt[2]), 32'(c2));
        chk({nm, "_e3"}, 32'(go_cnt[3]), 32'(c3));
        chk({nm, "_other"}, 32'(go_other), 32'd0);
    endtask

    initial begin
        int k, tot;
        repeat (3) @(negedge refClock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmdData", 32'(cmdData), 32'd0);
        reset_n = 1'b1;
        @(negedge refClock);

        // 1: clean pass
        mode = 0; clear_meas();
        pulse_start();
        wait_end("t1", 600);
        chk("t1_latency", 32'(first_go_cyc - start_cyc), 32'd12);
        chk("t1_data0", 32'(first_go_data), 32'h724110);
        chk_counts("t1", 1, 1, 1, 1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_error", 32'(error), 32'd0);

        // 2: entry 2 NACKed once
        mode = 1; nack2_left = 1; clear_meas();
        pulse_start();
        wait_end("t2", 600);
        chk_counts("t2", 1, 1, 2, 1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_fail", 32'(failIndex), 32'd0);

        // 3: entry 1 NACKed always
        mode = 2; clear_meas();
        pulse_start();
        wait_end("t3", 600);
        repeat (100) @(negedge refClock);
        chk_counts("t3", 1, 3, 0, 0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_fail", 32'(failIndex), 32'd1);
        chk("t3_gap_data", 32'(go_edges[2] - go_edges[1]), 32'd15);

        // 4: engine silent, timeouts
        mode = 3; clear_meas();
        pulse_start();
        chk("t4_err_cleared", 32'(error), 32'd0);
        wait_end("t4", 600);
        chk_counts("t4", 3, 0, 0, 0);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_fail", 32'(failIndex), 32'd0);
        chk("t4_period", 32'(go_edges[1] - go_edges[0]), 32'd74);
        mode = 0; clear_meas();
        pulse_start();
        chk("t4_restart_err", 32'(error), 32'd0);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_end("t4b", 600);
        chk("t4b_done", 32'(done), 32'd1);

        // 5: reset during WAIT, engine's late cmdDone must be ignored
        mode = 0; clear_meas();
        pulse_start();
        k = 0;
        while (cmdGo !== 1'b1 && k < 100) begin @(negedge refClock); k++; end
        if (k >= 100) begin n_cmp++; n_bad++; $display("FAIL t5_go: no cmdGo within 100 cycles"); end
        @(negedge refClock);
        reset_n = 1'b0;
        @(negedge refClock);
        reset_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_go", 32'(cmdGo), 32'd0);
        chk("t5_data", 32'(cmdData), 32'd0);
        tot = go_total;
        repeat (50) @(negedge refClock);
        chk("t5_no_activity", 32'(go_total - tot), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // 6: hot-plug
        clear_meas();
`ifdef HPD_RECONFIG_EN
        pulse_start();
        repeat (5) @(negedge refClock);
        hpd = 1'b1;
        wait_end("t6a", 600);
        k = 0;
        while (busy !== 1'b1 && k < 10) begin @(negedge refClock); k++; end
        chk("t6_restart", 32'(busy), 32'd1);
        wait_end("t6b", 600);
        chk("t6_total", 32'(go_total), 32'd8);
        chk("t6_done", 32'(done), 32'd1);
        hpd = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge refClock) hpd = 1'b1;
            repeat (3) @(negedge refClock);
            hpd = 1'b0;
        end
        repeat (40) @(negedge refClock);
        chk("t6_no_go", 32'(go_total), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
`endif
        repeat (3) @(negedge refClock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
